inst_fetch_ctrl: RTL and testbench



---
 rtl/inst_fetch_ctrl_pkg.sv | 43 ++++
 rtl/ifc_lat_cnt.sv | 37 +++
 rtl/inst_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared opcode map, instruction field layout and fetch FSM encodings.
// Latency: none, declarations only.
// Backpressure: none; used by the fetch controller and its latency counter.
package inst_fetch_ctrl_pkg;

    typedef enum logic [3:0] {
        D_MOV0 = 4'd0,
        D_MOV1 = 4'd1,
        D_MOV2 = 4'd2,
        D_MOV3 = 4'd3,
        D_ADD  = 4'd4,
        D_SUB  = 4'd5,
        D_JZ   = 4'd6,
        D_HALT = 4'd15
    } opcode_e;

    // Field positions: opc [15:12], op1 [11:8], op2 [7:0].
    typedef struct packed {
        logic [3:0] opc;
        logic [3:0] op1;
        logic [7:0] op2;
    } inst_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4,
        S_DONE  = 3'd5
`ifdef IFC_SINGLE_STEP_EN
        , S_STEP_WAIT = 3'd6
`endif
    } state_e;

    // Wide enough for IMEM_LAT-1 with IMEM_LAT up to 4.
    localparam int LAT_CNT_W = 2;

    function automatic logic opc_is_exec(input logic [3:0] opc);
        return opc <= 4'(D_JZ);
    endfunction

endpackage

// File: rtl/ifc_lat_cnt.sv
// Loadable down-counter timing the instruction-memory read latency.
// Latency: load/decrement take effect on the next clock; o_zero is combinational from the count.
// Backpressure: none; saturates at zero.
module ifc_lat_cnt
    import inst_fetch_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [LAT_CNT_W-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_zero
);

    logic [LAT_CNT_W-1:0] cnt_q;
    logic [LAT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch/sequence controller: PC, IR, decoder strobe, JZ resolution, HALT/illegal stop.
// Latency: IMEM_LAT+3 cycles minimum per instruction; IFC_SINGLE_STEP_EN adds i_STEP gating after each EXEC.
// Backpressure: stalls in EXEC until i_EXEC_DONE; i_START is ignored while busy.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int IMEM_LAT = 1
) (
    input  logic              i_SCLK,
    input  logic              i_RESETB,
    input  logic              i_START,
    output logic              o_IMEM_RD,
    output logic [ADDR_W-1:0] o_IMEM_ADDR,
    input  logic [15:0]       i_IMEM_DO,
    output logic              o_WR_INST,
    output logic [15:0]       o_DO,
    input  logic              i_EXEC_DONE,
    input  logic              i_ZERO,
`ifdef IFC_SINGLE_STEP_EN
    input  logic              i_STEP,
`endif
    output logic [ADDR_W-1:0] o_PC,
    output logic              o_BUSY,
    output logic              o_HALT,
    output logic              o_ERR
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    inst_t             ir_q, ir_d;
    logic              err_q, err_d;
    logic              imem_rd;
    logic              wr_inst;
    logic              lat_zero;

    ifc_lat_cnt u_lat_cnt (
        .clk        (i_SCLK),
        .rst_n      (i_RESETB),
        .i_load     (state_q == S_FETCH),
        .i_load_val (LAT_CNT_W'(IMEM_LAT - 1)),
        .i_dec      (state_q == S_WAIT),
        .o_zero     (lat_zero)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = err_q;
        imem_rd = 1'b0;
        wr_inst = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_START) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_rd = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_zero) begin
                    ir_d    = i_IMEM_DO;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (opc_is_exec(ir_q.opc)) begin
                    wr_inst = 1'b1;
                    state_d = S_EXEC;
                end else if (ir_q.opc == D_HALT) begin
                    state_d = S_DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_EXEC: begin
                if (i_EXEC_DONE) begin
                    // JZ target comes from op2, sized to the PC; otherwise fall through with wrap.
                    if ((ir_q.opc == D_JZ) && i_ZERO) begin
                        pc_d = ADDR_W'(ir_q.op2);
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
`ifdef IFC_SINGLE_STEP_EN
                    state_d = S_STEP_WAIT;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef IFC_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (i_STEP) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_SCLK or negedge i_RESETB) begin
        if (!i_RESETB) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    assign o_IMEM_RD   = imem_rd;
    assign o_IMEM_ADDR = pc_q;
    assign o_WR_INST   = wr_inst;
    assign o_DO        = ir_q;
    assign o_PC        = pc_q;
    assign o_HALT      = (state_q == S_DONE);
    assign o_ERR       = err_q;
    assign o_BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: one instance at IMEM_LAT=1 and one at IMEM_LAT=3.
module tb_inst_fetch_ctrl;

`ifdef IFC_SINGLE_STEP_EN
    localparam int SPACING = 5;
`else
    localparam int SPACING = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, exec_done, zero, step, start3;
    logic        imem_rd, wr_inst, busy, halt, err;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_do, do_w;
    logic        rd3, wr3, busy3, halt3, err3;
    logic [7:0]  addr3, pc3;
    logic [15:0] do3, p0, p1, p2;
    logic [15:0] mem [0:255];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] wr_do[$];
    int          wr_cyc[$];
    logic [7:0]  rd_addr[$];
    int          rd3_cyc[$];
    int          wr3_cyc[$];
    logic [15:0] wr3_do[$];

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.ADDR_W(8), .IMEM_LAT(1)) dut (
        .i_SCLK(clk), .i_RESETB(rst_n), .i_START(start),
        .o_IMEM_RD(imem_rd), .o_IMEM_ADDR(imem_addr), .i_IMEM_DO(imem_do),
        .o_WR_INST(wr_inst), .o_DO(do_w), .i_EXEC_DONE(exec_done), .i_ZERO(zero),
`ifdef IFC_SINGLE_STEP_EN
        .i_STEP(step),
`endif
        .o_PC(pc), .o_BUSY(busy), .o_HALT(halt), .o_ERR(err)
    );

    inst_fetch_ctrl #(.ADDR_W(8), .IMEM_LAT(3)) dut3 (
        .i_SCLK(clk), .i_RESETB(rst_n), .i_START(start3),
        .o_IMEM_RD(rd3), .o_IMEM_ADDR(addr3), .i_IMEM_DO(p2),
        .o_WR_INST(wr3), .o_DO(do3), .i_EXEC_DONE(1'b1), .i_ZERO(1'b0),
`ifdef IFC_SINGLE_STEP_EN
        .i_STEP(1'b1),
`endif
        .o_PC(pc3), .o_BUSY(busy3), .o_HALT(halt3), .o_ERR(err3)
    );

    // Single-cycle memory for dut, three-stage pipelined memory for dut3.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_rd) imem_do <= mem[imem_addr];
        p0 <= rd3 ? ((addr3 == 8'd0) ? 16'h0112 : 16'hF000) : 16'h0000;
        p1 <= p0;
        p2 <= p1;
    end

    always @(negedge clk) begin
        if (wr_inst) begin
            wr_do.push_back(do_w);
            wr_cyc.push_back(cyc);
        end
        if (imem_rd) rd_addr.push_back(imem_addr);
        if (rd3) rd3_cyc.push_back(cyc);
        if (wr3) begin
            wr3_cyc.push_back(cyc);
            wr3_do.push_back(do3);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halt && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, halt, 1);
    endtask

    task automatic wait_wr(input string tag);
        int n = 0;
        while (!wr_inst && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, wr_inst, 1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    initial begin
        int wb, rb, n, nrd;
        rst_n = 1'b0; start = 1'b0; exec_done = 1'b1; zero = 1'b0; step = 1'b1; start3 = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_eq("rst_rd", imem_rd, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_halt", halt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_pc", pc, 0);
        check_eq("idle_busy", busy, 0);

        // Reset asserted mid-WAIT while the PC is 2
        mem[0] = 16'h0112; mem[1] = 16'h1234; mem[2] = 16'h4012; mem[3] = 16'hF000;
        pulse_start();
        n = 0;
        while (!(imem_rd && imem_addr == 8'd2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("t1_reach_fetch2", imem_rd, 1);
        @(negedge clk);
        check_eq("t1_wait_busy", busy, 1);
        check_eq("t1_wait_pc", pc, 2);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t1_async_rd", imem_rd, 0);
        check_eq("t1_async_wr", wr_inst, 0);
        check_eq("t1_async_busy", busy, 0);
        check_eq("t1_async_halt", halt, 0);
        check_eq("t1_async_err", err, 0);
        check_eq("t1_async_pc", pc, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line program after the reset
        wb = wr_do.size();
        pulse_start();
        check_eq("t1_first_rd", imem_rd, 1);
        check_eq("t1_first_addr", imem_addr, 0);
        wait_halt("t2_halt_timeout");
        check_eq("t2_wr_count", wr_do.size() - wb, 3);
        check_eq("t2_do0", wr_do[wb], 16'h0112);
        check_eq("t2_do1", wr_do[wb+1], 16'h1234);
        check_eq("t2_do2", wr_do[wb+2], 16'h4012);
        check_eq("t2_space01", wr_cyc[wb+1] - wr_cyc[wb], SPACING);
        check_eq("t2_space12", wr_cyc[wb+2] - wr_cyc[wb+1], SPACING);
        check_eq("t2_pc", pc, 3);
        check_eq("t2_err", err, 0);
        check_eq("t2_busy", busy, 0);

        // JZ taken and not taken
        clear_mem();
        mem[0] = 16'h0112; mem[1] = 16'h1234; mem[2] = 16'h6105; mem[4] = 16'h0112;
        zero = 1'b1;
        rb = rd_addr.size();
        pulse_start();
        wait_halt("t3a_halt_timeout");
        check_eq("t3a_rd_count", rd_addr.size() - rb, 4);
        check_eq("t3a_target", rd_addr[rb+3], 5);
        check_eq("t3a_pc", pc, 5);
        zero = 1'b0;
        rb = rd_addr.size();
        pulse_start();
        wait_halt("t3b_halt_timeout");
        check_eq("t3b_next", rd_addr[rb+3], 3);
        check_eq("t3b_pc", pc, 3);

        // Illegal opcode
        clear_mem();
        mem[0] = 16'h0112; mem[1] = 16'h9ABC;
        wb = wr_do.size();
        pulse_start();
        wait_halt("t4_halt_timeout");
        check_eq("t4_wr_count", wr_do.size() - wb, 1);
        check_eq("t4_err", err, 1);
        check_eq("t4_pc", pc, 1);
        pulse_start();
        check_eq("t4_err_clr", err, 0);
        check_eq("t4_restart_rd", imem_rd, 1);
        check_eq("t4_restart_addr", imem_addr, 0);
        wait_halt("t4b_halt_timeout");

        // EXEC stall, START while busy, EXEC_DONE outside EXEC
        clear_mem();
        mem[0] = 16'h0112; mem[1] = 16'h4012;
        exec_done = 1'b0;
        pulse_start();
        wait_wr("t5_wr_timeout");
        nrd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (imem_rd) nrd++;
            if (i == 1) start = 1'b1;
            if (i == 2) start = 1'b0;
        end
        check_eq("t5_stall_rd", nrd, 0);
        check_eq("t5_stall_pc", pc, 0);
        check_eq("t5_stall_busy", busy, 1);
        exec_done = 1'b1;
        @(negedge clk);
`ifdef IFC_SINGLE_STEP_EN
        @(negedge clk);
`endif
        check_eq("t5_fetch_rd", imem_rd, 1);
        check_eq("t5_fetch_addr", imem_addr, 1);
        exec_done = 1'b0;
        wait_wr("t5_wr2_timeout");
        nrd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (imem_rd) nrd++;
        end
        check_eq("t5_ignored_done_rd", nrd, 0);
        check_eq("t5_ignored_done_pc", pc, 1);
        exec_done = 1'b1;
        wait_halt("t5_halt_timeout");
        check_eq("t5_pc", pc, 2);

        // IMEM_LAT=3 timing
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("t6_lat3_rd_seen", rd3_cyc.size() >= 1, 1);
        check_eq("t6_lat3_gap", wr3_cyc[0] - rd3_cyc[0], 4);
        check_eq("t6_lat3_do", wr3_do[0], 16'h0112);
        check_eq("t6_lat3_halt", halt3, 1);
        check_eq("t6_lat3_pc", pc3, 1);

        // PC wrap from 255 to 0
        clear_mem();
        mem[0] = 16'h60FF; mem[255] = 16'h4012;
        zero = 1'b1;
        rb = rd_addr.size();
        pulse_start();
        n = 0;
        while (!(imem_rd && imem_addr == 8'd255) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_reach_255", imem_addr, 255);
        zero = 1'b0;
        wait_halt("t6_wrap_halt_timeout");
        check_eq("t6_wrap_next", rd_addr[rb+2], 0);
        check_eq("t6_wrap_after", rd_addr[rb+3], 1);
        check_eq("t6_wrap_pc", pc, 1);

`ifdef IFC_SINGLE_STEP_EN
        clear_mem();
        mem[0] = 16'h0112;
        step = 1'b0;
        pulse_start();
        wait_wr("t6_step_wr_timeout");
        nrd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (imem_rd) nrd++;
        end
        check_eq("t6_step_hold_rd", nrd, 0);
        check_eq("t6_step_busy", busy, 1);
        check_eq("t6_step_pc", pc, 1);
        step = 1'b1;
        @(negedge clk);
        check_eq("t6_step_fetch", imem_rd, 1);
        check_eq("t6_step_addr", imem_addr, 1);
        wait_halt("t6_step_halt_timeout");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
